// File: rtl/conv_gpio_ctrl.sv
// conv_gpio_ctrl
//   Command sequencer between a software-paced GPIO word and a 2D convolution datapath.
//   Each rising edge of i_gpio_valid triggers exactly one action, chosen by i_gpio_ctrl:
//     000 kernel row write, 010 pixel write, 100 last pixel write and start,
//     011 step the result read pointer. Command 001 loads the image length at level.
//   After the last pixel it pulses o_conv_start, waits for i_conv_done, then raises o_led.
// Ports
//   clk, rst           clock, synchronous active-high reset
//   i_gpio_*           GPIO payload, command and strobe
//   o_kernel_*         kernel row data and one-hot row write enable
//   o_img_len          last column address (image length - 1)
//   o_mem_*            image bank write data, address and one-hot bank enable
//   o_conv_start       one-cycle convolver start pulse
//   i_conv_done        convolvers finished (level)
//   o_rd_bank/addr     result read pointer; i_rd_data returns one cycle later
//   o_gpio_data        registered, zero-extended result word
//   o_led              convolution complete
module conv_gpio_ctrl #(
   parameter int unsigned NB_DATA = 24,
   parameter int unsigned N_CONV  = 2,
   parameter int unsigned NB_ADDR = 10,
   parameter int unsigned NB_OUT  = 13,
   parameter int unsigned NB_GPIO = 32,
   localparam int unsigned NB_BANK = $clog2(N_CONV) + 1,
   localparam int unsigned N_IMG   = N_CONV + 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NB_DATA-1:0] i_gpio_data,
   input  logic [2:0]         i_gpio_ctrl,
   input  logic               i_gpio_valid,
   output logic [NB_DATA-1:0] o_kernel_data,
   output logic [2:0]         o_kernel_we,
   output logic [NB_ADDR-1:0] o_img_len,
   output logic [NB_DATA-1:0] o_mem_data,
   output logic [NB_ADDR-1:0] o_mem_addr,
   output logic [N_IMG-1:0]   o_mem_we,
   output logic               o_conv_start,
   input  logic               i_conv_done,
   output logic [NB_BANK-1:0] o_rd_bank,
   output logic [NB_ADDR-1:0] o_rd_addr,
   input  logic [NB_OUT-1:0]  i_rd_data,
   output logic [NB_GPIO-1:0] o_gpio_data,
   output logic               o_led
);

   localparam int unsigned NB_BCNT = $clog2(N_IMG);

   localparam logic [2:0] CmdKernel = 3'b000;
   localparam logic [2:0] CmdLen    = 3'b001;
   localparam logic [2:0] CmdPixel  = 3'b010;
   localparam logic [2:0] CmdRead   = 3'b011;
   localparam logic [2:0] CmdLast   = 3'b100;

   typedef enum logic [1:0] {StLoad, StRun, StDone} state_e;

   state_e               state_q, state_d;
   logic                 valid_q, valid_d;
   logic [1:0]           k_cnt_q, k_cnt_d;
   logic [NB_ADDR-1:0]   a_cnt_q, a_cnt_d;
   logic [NB_BCNT-1:0]   b_cnt_q, b_cnt_d;
   logic [NB_ADDR-1:0]   img_len_q, img_len_d;
   logic [NB_DATA-1:0]   kernel_data_q, kernel_data_d;
   logic [2:0]           kernel_we_q, kernel_we_d;
   logic [NB_DATA-1:0]   mem_data_q, mem_data_d;
   logic [NB_ADDR-1:0]   mem_addr_q, mem_addr_d;
   logic [N_IMG-1:0]     mem_we_q, mem_we_d;
   logic                 start_pend_q, start_pend_d;
   logic                 conv_start_q, conv_start_d;
   logic [NB_BANK-1:0]   rd_bank_q, rd_bank_d;
   logic [NB_ADDR-1:0]   rd_addr_q, rd_addr_d;
   logic [NB_GPIO-1:0]   gpio_data_q, gpio_data_d;
   logic                 led_q, led_d;
   logic                 rise;
   logic                 do_write;

   always_comb begin
      rise          = i_gpio_valid & ~valid_q;
      do_write      = 1'b0;
      valid_d       = i_gpio_valid;
      state_d       = state_q;
      k_cnt_d       = k_cnt_q;
      a_cnt_d       = a_cnt_q;
      b_cnt_d       = b_cnt_q;
      img_len_d     = img_len_q;
      kernel_data_d = kernel_data_q;
      kernel_we_d   = '0;
      mem_data_d    = mem_data_q;
      mem_addr_d    = mem_addr_q;
      mem_we_d      = '0;
      start_pend_d  = 1'b0;
      // Start fires one cycle after the final pixel write leaves the block.
      conv_start_d  = start_pend_q;
      rd_bank_d     = rd_bank_q;
      rd_addr_d     = rd_addr_q;
      gpio_data_d   = NB_GPIO'(i_rd_data);
      led_d         = led_q;

      unique case (state_q)
         StLoad: begin
            if (i_gpio_ctrl == CmdLen) begin
               img_len_d = i_gpio_data[NB_ADDR-1:0];
            end
            if (rise) begin
               case (i_gpio_ctrl)
                  CmdKernel: begin
                     kernel_data_d = i_gpio_data;
                     kernel_we_d   = 3'b001 << k_cnt_q;
                     k_cnt_d       = (k_cnt_q == 2'd2) ? 2'd0 : k_cnt_q + 2'd1;
                  end
                  CmdPixel: do_write = 1'b1;
                  CmdLast: begin
                     do_write     = 1'b1;
                     start_pend_d = 1'b1;
                     state_d      = StRun;
                  end
                  default: ;
               endcase
            end
         end
         StRun: begin
            // Ignore done during the pending and pulse cycles so a stale done cannot
            // complete a run that has not started yet.
            if (i_conv_done && !start_pend_q && !conv_start_q) begin
               state_d = StDone;
               led_d   = 1'b1;
            end
         end
         StDone: begin
            if (rise && i_gpio_ctrl == CmdRead) begin
               if (rd_addr_q == img_len_q - NB_ADDR'(2)) begin
                  rd_addr_d = '0;
                  rd_bank_d = (rd_bank_q == NB_BANK'(N_CONV - 1)) ? '0 : rd_bank_q + 1'b1;
               end else begin
                  rd_addr_d = rd_addr_q + 1'b1;
               end
            end else if (rise && i_gpio_ctrl == CmdKernel) begin
               // Reload: the same strobe writes kernel row 0.
               state_d       = StLoad;
               led_d         = 1'b0;
               a_cnt_d       = '0;
               b_cnt_d       = '0;
               rd_addr_d     = '0;
               rd_bank_d     = '0;
               k_cnt_d       = 2'd1;
               kernel_data_d = i_gpio_data;
               kernel_we_d   = 3'b001;
            end
         end
         default: state_d = StLoad;
      endcase

      if (do_write) begin
         mem_we_d   = N_IMG'(1) << b_cnt_q;
         mem_addr_d = a_cnt_q;
         mem_data_d = i_gpio_data;
         if (a_cnt_q == img_len_q) begin
            a_cnt_d = '0;
            b_cnt_d = (b_cnt_q == NB_BCNT'(N_IMG - 1)) ? '0 : b_cnt_q + 1'b1;
         end else begin
            a_cnt_d = a_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StLoad;
         valid_q       <= 1'b0;
         k_cnt_q       <= '0;
         a_cnt_q       <= '0;
         b_cnt_q       <= '0;
         img_len_q     <= '0;
         kernel_data_q <= '0;
         kernel_we_q   <= '0;
         mem_data_q    <= '0;
         mem_addr_q    <= '0;
         mem_we_q      <= '0;
         start_pend_q  <= 1'b0;
         conv_start_q  <= 1'b0;
         rd_bank_q     <= '0;
         rd_addr_q     <= '0;
         gpio_data_q   <= '0;
         led_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         valid_q       <= valid_d;
         k_cnt_q       <= k_cnt_d;
         a_cnt_q       <= a_cnt_d;
         b_cnt_q       <= b_cnt_d;
         img_len_q     <= img_len_d;
         kernel_data_q <= kernel_data_d;
         kernel_we_q   <= kernel_we_d;
         mem_data_q    <= mem_data_d;
         mem_addr_q    <= mem_addr_d;
         mem_we_q      <= mem_we_d;
         start_pend_q  <= start_pend_d;
         conv_start_q  <= conv_start_d;
         rd_bank_q     <= rd_bank_d;
         rd_addr_q     <= rd_addr_d;
         gpio_data_q   <= gpio_data_d;
         led_q         <= led_d;
      end
   end

   assign o_kernel_data = kernel_data_q;
   assign o_kernel_we   = kernel_we_q;
   assign o_img_len     = img_len_q;
   assign o_mem_data    = mem_data_q;
   assign o_mem_addr    = mem_addr_q;
   assign o_mem_we      = mem_we_q;
   assign o_conv_start  = conv_start_q;
   assign o_rd_bank     = rd_bank_q;
   assign o_rd_addr     = rd_addr_q;
   assign o_gpio_data   = gpio_data_q;
   assign o_led         = led_q;

endmodule

// File: tb/tb_conv_gpio_ctrl.sv
// Directed bench for conv_gpio_ctrl: kernel, pixel load, run/done, read-out, reload, reset.
module tb_conv_gpio_ctrl;

   logic        clk;
   logic        rst;
   logic [23:0] i_gpio_data;
   logic [2:0]  i_gpio_ctrl;
   logic        i_gpio_valid;
   logic [23:0] o_kernel_data;
   logic [2:0]  o_kernel_we;
   logic [9:0]  o_img_len;
   logic [23:0] o_mem_data;
   logic [9:0]  o_mem_addr;
   logic [3:0]  o_mem_we;
   logic        o_conv_start;
   logic        i_conv_done;
   logic [1:0]  o_rd_bank;
   logic [9:0]  o_rd_addr;
   logic [12:0] i_rd_data;
   logic [31:0] o_gpio_data;
   logic        o_led;

   int n_vec = 0;
   int n_err = 0;
   logic [23:0] kd [3] = '{24'h002000, 24'h208020, 24'h002000};

   conv_gpio_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .i_gpio_data  (i_gpio_data),
      .i_gpio_ctrl  (i_gpio_ctrl),
      .i_gpio_valid (i_gpio_valid),
      .o_kernel_data(o_kernel_data),
      .o_kernel_we  (o_kernel_we),
      .o_img_len    (o_img_len),
      .o_mem_data   (o_mem_data),
      .o_mem_addr   (o_mem_addr),
      .o_mem_we     (o_mem_we),
      .o_conv_start (o_conv_start),
      .i_conv_done  (i_conv_done),
      .o_rd_bank    (o_rd_bank),
      .o_rd_addr    (o_rd_addr),
      .i_rd_data    (i_rd_data),
      .o_gpio_data  (o_gpio_data),
      .o_led        (o_led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Result memory contents, distinct per bank/address.
   function automatic logic [12:0] rd_model(input logic [1:0] b, input logic [9:0] a);
      return 13'((int'(b) * 1237 + int'(a) * 91 + 165) % 8192);
   endfunction

   // Synchronous-read result memory.
   always @(posedge clk) i_rd_data <= rd_model(o_rd_bank, o_rd_addr);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] c, input logic [23:0] d);
      i_gpio_ctrl  = c;
      i_gpio_data  = d;
      i_gpio_valid = 1'b1;
      step();
   endtask

   task automatic idle();
      i_gpio_valid = 1'b0;
      step();
   endtask

   task automatic test_reset();
      logic [120:0] allo;
      step(); step();
      allo = {o_kernel_data, o_kernel_we, o_img_len, o_mem_data, o_mem_addr, o_mem_we,
              o_conv_start, o_rd_bank, o_rd_addr, o_gpio_data, o_led};
      n_vec++;
      if (allo !== '0) begin n_err++; $display("FAIL reset_init: got %h want 0", allo); end
      rst = 1'b0; step();
      i_gpio_ctrl = 3'b001; i_gpio_data = 24'd5; step();
      drive(3'b000, 24'habcdef); idle();
      drive(3'b010, 24'h123456); idle();
      rst = 1'b1; step();
      allo = {o_kernel_data, o_kernel_we, o_img_len, o_mem_data, o_mem_addr, o_mem_we,
              o_conv_start, o_rd_bank, o_rd_addr, o_gpio_data, o_led};
      n_vec++;
      if (allo !== '0) begin n_err++; $display("FAIL reset_dirty: got %h want 0", allo); end
      rst = 1'b0; idle();
   endtask

   task automatic test_kernel();
      logic [2:0] ew;
      int cnt;
      for (int i = 0; i < 3; i++) begin
         ew = 3'b001 << i;
         drive(3'b000, kd[i]);
         n_vec++;
         if (o_kernel_we !== ew || o_kernel_data !== kd[i]) begin
            n_err++;
            $display("FAIL kernel[%0d]: got we=%b d=%h want we=%b d=%h", i, o_kernel_we,
                     o_kernel_data, ew, kd[i]);
         end
         cnt = 0;
         for (int c = 0; c < 24; c++) begin
            step();
            if (o_kernel_we !== 3'b000) cnt++;
         end
         n_vec++;
         if (cnt != 0) begin n_err++; $display("FAIL kernel_hold[%0d]: got %0d extra writes want 0", i, cnt); end
         idle();
      end
      drive(3'b000, 24'h00ffff);
      n_vec++;
      if (o_kernel_we !== 3'b001) begin n_err++; $display("FAIL kernel_wrap: got %b want 001", o_kernel_we); end
      idle();
   endtask

   task automatic test_load();
      logic [3:0]  ew;
      logic [23:0] d;
      i_gpio_ctrl = 3'b001; i_gpio_data = 24'd15; i_gpio_valid = 1'b0; step();
      n_vec++;
      if (o_img_len !== 10'd15) begin n_err++; $display("FAIL img_len: got %0d want 15", o_img_len); end
      for (int i = 0; i < 64; i++) begin
         ew = 4'(1 << (i / 16));
         d  = 24'h100000 + 24'(i * 3);
         drive(3'b010, d);
         n_vec++;
         if (o_mem_we !== ew || o_mem_addr !== 10'(i % 16) || o_mem_data !== d) begin
            n_err++;
            $display("FAIL pixel[%0d]: got we=%b a=%0d d=%h want we=%b a=%0d d=%h", i, o_mem_we,
                     o_mem_addr, o_mem_data, ew, i % 16, d);
         end
         idle();
         n_vec++;
         if (o_mem_we !== 4'b0000) begin n_err++; $display("FAIL pixel_drop[%0d]: got %b want 0000", i, o_mem_we); end
      end
      drive(3'b011, 24'h000001);
      n_vec++;
      if (o_mem_we !== 4'b0 || o_kernel_we !== 3'b0 || o_img_len !== 10'd15) begin
         n_err++;
         $display("FAIL load_ignore011: got mwe=%b kwe=%b len=%0d want 0 0 15", o_mem_we, o_kernel_we, o_img_len);
      end
      idle();
   endtask

   task automatic test_run();
      drive(3'b100, 24'h0badad);
      n_vec++;
      if (o_mem_we !== 4'b0001 || o_mem_addr !== 10'd0 || o_mem_data !== 24'h0badad || o_conv_start !== 1'b0) begin
         n_err++;
         $display("FAIL last_pixel: got we=%b a=%0d d=%h st=%b want 0001 0 0badad 0", o_mem_we, o_mem_addr,
                  o_mem_data, o_conv_start);
      end
      idle();
      n_vec++;
      if (o_conv_start !== 1'b1 || o_mem_we !== 4'b0) begin
         n_err++; $display("FAIL start_pulse: got st=%b we=%b want 1 0000", o_conv_start, o_mem_we);
      end
      idle();
      n_vec++;
      if (o_conv_start !== 1'b0) begin n_err++; $display("FAIL start_end: got %b want 0", o_conv_start); end
      drive(3'b010, 24'h111111);
      n_vec++;
      if (o_mem_we !== 4'b0 || o_led !== 1'b0) begin
         n_err++; $display("FAIL run_ignore_pixel: got we=%b led=%b want 0000 0", o_mem_we, o_led);
      end
      idle();
      drive(3'b000, 24'h222222);
      n_vec++;
      if (o_kernel_we !== 3'b0) begin n_err++; $display("FAIL run_ignore_kernel: got %b want 000", o_kernel_we); end
      idle();
      drive(3'b100, 24'h333333);
      n_vec++;
      if (o_mem_we !== 4'b0 || o_conv_start !== 1'b0) begin
         n_err++; $display("FAIL run_ignore_last: got we=%b st=%b want 0000 0", o_mem_we, o_conv_start);
      end
      idle();
      i_conv_done = 1'b1; step();
      n_vec++;
      if (o_led !== 1'b1) begin n_err++; $display("FAIL led_on: got %b want 1", o_led); end
      i_conv_done = 1'b0; step(); step();
      n_vec++;
      if (o_led !== 1'b1) begin n_err++; $display("FAIL led_hold: got %b want 1", o_led); end
   endtask

   task automatic test_readout();
      int idx;
      logic [1:0]  eb;
      logic [9:0]  ea;
      logic [31:0] eg;
      step(); step();
      eg = {19'b0, rd_model(2'd0, 10'd0)};
      n_vec++;
      if (o_rd_bank !== 2'd0 || o_rd_addr !== 10'd0 || o_gpio_data !== eg) begin
         n_err++;
         $display("FAIL read_init: got b=%0d a=%0d g=%h want 0 0 %h", o_rd_bank, o_rd_addr, o_gpio_data, eg);
      end
      // img_len 15 -> 14 addresses per bank, 2 banks, 28-step cycle.
      for (int k = 1; k <= 30; k++) begin
         idx = k % 28;
         eb  = 2'(idx / 14);
         ea  = 10'(idx % 14);
         eg  = {19'b0, rd_model(eb, ea)};
         drive(3'b011, 24'h0);
         n_vec++;
         if (o_rd_bank !== eb || o_rd_addr !== ea) begin
            n_err++; $display("FAIL read_ptr[%0d]: got b=%0d a=%0d want b=%0d a=%0d", k, o_rd_bank, o_rd_addr, eb, ea);
         end
         step(); step();
         n_vec++;
         if (o_gpio_data !== eg || o_rd_addr !== ea || o_rd_bank !== eb) begin
            n_err++;
            $display("FAIL read_data[%0d]: got g=%h b=%0d a=%0d want g=%h b=%0d a=%0d", k, o_gpio_data,
                     o_rd_bank, o_rd_addr, eg, eb, ea);
         end
         idle();
      end
   endtask

   task automatic test_reload();
      drive(3'b000, 24'h00c0de);
      n_vec++;
      if (o_led !== 1'b0 || o_kernel_we !== 3'b001 || o_kernel_data !== 24'h00c0de ||
          o_rd_bank !== 2'd0 || o_rd_addr !== 10'd0) begin
         n_err++;
         $display("FAIL reload: got led=%b we=%b d=%h b=%0d a=%0d want 0 001 00c0de 0 0", o_led,
                  o_kernel_we, o_kernel_data, o_rd_bank, o_rd_addr);
      end
      idle();
      drive(3'b000, 24'h00beef);
      n_vec++;
      if (o_kernel_we !== 3'b010) begin n_err++; $display("FAIL reload_row1: got %b want 010", o_kernel_we); end
      idle();
      i_gpio_ctrl = 3'b001; i_gpio_data = 24'h000000; step();
      n_vec++;
      if (o_img_len !== 10'd0) begin n_err++; $display("FAIL img_len0: got %0d want 0", o_img_len); end
   endtask

   task automatic test_early_done();
      logic [3:0] ew;
      i_conv_done = 1'b1;
      for (int b = 0; b < 3; b++) begin
         ew = 4'(1 << b);
         drive(3'b010, 24'h400000 + 24'(b));
         n_vec++;
         if (o_mem_we !== ew || o_mem_addr !== 10'd0) begin
            n_err++; $display("FAIL len0_pixel[%0d]: got we=%b a=%0d want we=%b a=0", b, o_mem_we, o_mem_addr, ew);
         end
         idle();
      end
      drive(3'b100, 24'h4000ff);
      n_vec++;
      if (o_mem_we !== 4'b1000 || o_mem_addr !== 10'd0 || o_led !== 1'b0) begin
         n_err++; $display("FAIL len0_last: got we=%b a=%0d led=%b want 1000 0 0", o_mem_we, o_mem_addr, o_led);
      end
      idle();
      n_vec++;
      if (o_conv_start !== 1'b1 || o_led !== 1'b0) begin
         n_err++; $display("FAIL early_pulse: got st=%b led=%b want 1 0", o_conv_start, o_led);
      end
      step();
      n_vec++;
      if (o_conv_start !== 1'b0 || o_led !== 1'b0) begin
         n_err++; $display("FAIL early_gap: got st=%b led=%b want 0 0", o_conv_start, o_led);
      end
      step();
      n_vec++;
      if (o_led !== 1'b1) begin n_err++; $display("FAIL early_led: got %b want 1", o_led); end
      i_conv_done = 1'b0;
   endtask

   task automatic test_reset_midload();
      logic [120:0] allo;
      drive(3'b000, 24'h000001); idle();
      drive(3'b010, 24'h000005);
      n_vec++;
      if (o_mem_we !== 4'b0001) begin n_err++; $display("FAIL mid_pix0: got %b want 0001", o_mem_we); end
      idle();
      drive(3'b010, 24'h000006);
      n_vec++;
      if (o_mem_we !== 4'b0010) begin n_err++; $display("FAIL mid_pix1: got %b want 0010", o_mem_we); end
      rst = 1'b1; step();
      allo = {o_kernel_data, o_kernel_we, o_img_len, o_mem_data, o_mem_addr, o_mem_we,
              o_conv_start, o_rd_bank, o_rd_addr, o_gpio_data, o_led};
      n_vec++;
      if (allo !== '0) begin n_err++; $display("FAIL mid_reset: got %h want 0", allo); end
      rst = 1'b0; i_gpio_valid = 1'b0; step();
      drive(3'b010, 24'h000009);
      n_vec++;
      if (o_mem_we !== 4'b0001 || o_mem_addr !== 10'd0) begin
         n_err++; $display("FAIL post_reset_pix: got we=%b a=%0d want 0001 0", o_mem_we, o_mem_addr);
      end
      idle();
      drive(3'b000, 24'h00000a);
      n_vec++;
      if (o_kernel_we !== 3'b001) begin n_err++; $display("FAIL post_reset_kernel: got %b want 001", o_kernel_we); end
      idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      i_gpio_data  = '0;
      i_gpio_ctrl  = '0;
      i_gpio_valid = 1'b0;
      i_conv_done  = 1'b0;
      test_reset();
      test_kernel();
      test_load();
      test_run();
      test_readout();
      test_reload();
      test_early_done();
      test_reset_midload();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
